animated_sprite_bitmap: RTL and testbench
=========================================

ANIMATED_SPRITE_BITMAP -- requirements
Module: animated_sprite_bitmap

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- OBJECT_WIDTH_X, 26, bitmap columns.
- OBJECT_HEIGHT_Y, 26, bitmap rows.
- NUM_FRAMES, 2, animation frames, 1..8.
- SCALE_SHIFT, 1, screen pixels per bitmap pixel = 2^SCALE_SHIFT per axis, 0..3.
- FRAME_PERIOD, 16, video frames per animation step, >=1.
- EXPLODE_FRAMES, 24, video frames the explosion image is shown, >=1.
- TRANSPARENT_ENCODING, 8'hFF, colour value meaning "do not draw".
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, pixel clock.
- resetN, in, 1, reset; asynchronous, active-low; clock is clk.
- offsetX, in, 11, pixel X offset from sprite top-left.
- offsetY, in, 11, pixel Y offset from sprite top-left.
- InsideRectangle, in, 1, pixel lies within the sprite bracket.
- startOfFrame, in, 1, one-cycle pulse per video frame.
- hit, in, 1, one-cycle collision pulse.
- revive, in, 1, one-cycle pulse returning the sprite to life.
- drawingRequest, out, 1, pixel is to be displayed.
- RGBout, out, 8, pixel colour.
- exploding, out, 1, high in state EXPLODING.
- dead, out, 1, high in state DEAD.

Function
REQ-003 Bitmap address SHALL be row = offsetY >> SCALE_SHIFT, col = offsetX >> SCALE_SHIFT; row >= OBJECT_HEIGHT_Y or col >= OBJECT_WIDTH_X SHALL yield TRANSPARENT_ENCODING.
REQ-004 RGBout SHALL be registered, with one clk of latency from offsetX/offsetY/InsideRectangle to RGBout.
REQ-005 InsideRectangle=0 SHALL yield RGBout=TRANSPARENT_ENCODING on the next clk.
REQ-006 drawingRequest SHALL be combinational: 1 iff RGBout != TRANSPARENT_ENCODING.
REQ-007 The FSM SHALL have the states ALIVE, EXPLODING and DEAD; exploding and dead SHALL be decoded directly from the state register.
REQ-008 In ALIVE, a frame-step counter SHALL increment on each startOfFrame.
- At FRAME_PERIOD-1 the counter SHALL clear and the frame index SHALL advance, wrapping NUM_FRAMES-1 -> 0.
- NUM_FRAMES=1 SHALL hold the frame index at 0.
REQ-009 ALIVE SHALL show animation frame[frame index]; EXPLODING SHALL show the dedicated explosion image; DEAD SHALL force RGBout=TRANSPARENT_ENCODING.
REQ-010 hit in ALIVE SHALL go to EXPLODING on the next clk and clear the counter.
- In EXPLODING the counter SHALL count startOfFrame pulses.
- At EXPLODE_FRAMES-1 it SHALL go to DEAD.
REQ-011 hit in EXPLODING or DEAD SHALL be ignored.
REQ-012 revive in any state SHALL go to ALIVE with frame index 0 and counter 0; revive SHALL take priority over a simultaneous hit.
REQ-013 hit coinciding with a startOfFrame that would advance the frame SHALL enter EXPLODING with the counter 0; the frame index update is don't-care.
REQ-014 A state change SHALL affect pixel colour from the first pixel clocked after the transition; no mid-frame hold is required.
REQ-015 The counter SHALL be sized $clog2(max(FRAME_PERIOD, EXPLODE_FRAMES)+1) bits; the frame index SHALL be $clog2(NUM_FRAMES) bits, minimum 1.

Reset
REQ-016 resetN low SHALL asynchronously set state=ALIVE, frame index=0, counter=0 and RGBout=TRANSPARENT_ENCODING, giving drawingRequest=0, exploding=0, dead=0.
REQ-017 Reset asserted mid-explosion SHALL abandon the explosion; after release the sprite SHALL be ALIVE at frame 0.

Structure
REQ-018 Package sprite_pkg SHALL hold the FSM state enum (ALIVE, EXPLODING, DEAD) and the TRANSPARENT_ENCODING default.
REQ-019 Bitmap storage SHALL be a sub-module sprite_rom.
- Inputs: image select (0..NUM_FRAMES-1 animation frames, NUM_FRAMES = explosion), row, col.
- Output: combinational 8-bit colour.
- The register SHALL reside in animated_sprite_bitmap.

Verification
REQ-020 Reset release, InsideRectangle=1, offset (0,0), pixel transparent -> drawingRequest=0 and RGBout=8'hFF throughout reset and after.
REQ-021 SCALE_SHIFT=1, offset (19,21) -> RGBout = frame0[10][9] exactly one clk later; offsetX=60 -> 8'hFF.
REQ-022 FRAME_PERIOD=16, NUM_FRAMES=2:
- 16 startOfFrame pulses -> frame index 1.
- 32 pulses -> back to 0.
REQ-023 hit in ALIVE -> exploding=1 next clk, explosion image drawn; after 24 startOfFrame -> dead=1 and drawingRequest=0 everywhere.
REQ-024 hit and revive in the same clk while EXPLODING -> ALIVE at frame 0, exploding=0.
REQ-025 resetN low after 10 explosion frames -> after release ALIVE at frame 0, dead=0; hit during DEAD -> no state change.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite: the life-cycle state
// encoding and the default "do not draw" colour.
package sprite_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        EXPLODING = 2'd1,
        DEAD      = 2'd2
    } sprite_state_t;

    localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite image store: images 0..NUM_FRAMES-1 are animation
// frames, image NUM_FRAMES is the explosion.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int unsigned OBJECT_WIDTH_X       = 26,
    parameter int unsigned OBJECT_HEIGHT_Y      = 26,
    parameter int unsigned NUM_FRAMES           = 2,
    parameter logic [7:0]  TRANSPARENT_ENCODING = TRANSPARENT_DEFAULT,
    localparam int unsigned IMG_W               = $clog2(NUM_FRAMES + 1)
) (
    input  logic [IMG_W-1:0] img,
    input  logic [10:0]      row,
    input  logic [10:0]      col,
    output logic [7:0]       colour_c
);

    // Procedurally generated art: animation frames have a transparent top row
    // and left column; the explosion image is fully opaque.
    always_comb begin
        colour_c = TRANSPARENT_ENCODING;
        if (row < 11'(OBJECT_HEIGHT_Y) && col < 11'(OBJECT_WIDTH_X)) begin
            if (img == IMG_W'(NUM_FRAMES)) begin
                colour_c = {4'hC, row[3:0] ^ col[3:0]};
            end else if (row != 11'd0 && col != 11'd0) begin
                colour_c = {1'b0, 3'(img), 4'(row[3:0] + col[3:0])};
            end
        end
    end

endmodule

// File: rtl/animated_sprite_bitmap.sv
// Animated sprite pixel source with an ALIVE -> EXPLODING -> DEAD life cycle
// driven by video-frame pulses, collision hits and revive requests.
module animated_sprite_bitmap
    import sprite_pkg::*;
#(
    parameter int unsigned OBJECT_WIDTH_X       = 26,
    parameter int unsigned OBJECT_HEIGHT_Y      = 26,
    parameter int unsigned NUM_FRAMES           = 2,
    parameter int unsigned SCALE_SHIFT          = 1,
    parameter int unsigned FRAME_PERIOD         = 16,
    parameter int unsigned EXPLODE_FRAMES       = 24,
    parameter logic [7:0]  TRANSPARENT_ENCODING = TRANSPARENT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic        startOfFrame,
    input  logic        hit,
    input  logic        revive,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        exploding,
    output logic        dead
);

    localparam int unsigned CNT_MAX = (FRAME_PERIOD > EXPLODE_FRAMES) ? FRAME_PERIOD : EXPLODE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FI_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int unsigned IMG_W   = $clog2(NUM_FRAMES + 1);

    sprite_state_t    state_q, state_d;
    logic [FI_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rgb_q, rgb_d;

    logic [10:0]      row_c, col_c;
    logic [IMG_W-1:0] img_c;
    logic [7:0]       rom_colour_c;

    assign row_c = offsetY >> SCALE_SHIFT;
    assign col_c = offsetX >> SCALE_SHIFT;
    assign img_c = (state_q == EXPLODING) ? IMG_W'(NUM_FRAMES) : IMG_W'(frame_q);

    sprite_rom #(
        .OBJECT_WIDTH_X       (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y      (OBJECT_HEIGHT_Y),
        .NUM_FRAMES           (NUM_FRAMES),
        .TRANSPARENT_ENCODING (TRANSPARENT_ENCODING)
    ) u_rom (
        .img      (img_c),
        .row      (row_c),
        .col      (col_c),
        .colour_c (rom_colour_c)
    );

    // Life-cycle and animation sequencing; revive overrides everything.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        if (revive) begin
            state_d = ALIVE;
            frame_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit) begin
                        state_d = EXPLODING;
                        cnt_d   = '0;
                    end else if (startOfFrame) begin
                        if (cnt_q == CNT_W'(FRAME_PERIOD - 1)) begin
                            cnt_d   = '0;
                            frame_d = (frame_q == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FI_W'(1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                EXPLODING: begin
                    if (startOfFrame) begin
                        if (cnt_q == CNT_W'(EXPLODE_FRAMES - 1)) begin
                            state_d = DEAD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel colour uses the current state, so a transition shows on the next pixel.
    always_comb begin
        rgb_d = TRANSPARENT_ENCODING;
        if (InsideRectangle && state_q != DEAD) begin
            rgb_d = rom_colour_c;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ALIVE;
            frame_q <= '0;
            cnt_q   <= '0;
            rgb_q   <= TRANSPARENT_ENCODING;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
        end
    end

    assign RGBout         = rgb_q;
    assign drawingRequest = (rgb_q != TRANSPARENT_ENCODING);
    assign exploding      = (state_q == EXPLODING);
    assign dead           = (state_q == DEAD);

endmodule

// File: tb/tb_animated_sprite_bitmap.sv
// Directed bench for animated_sprite_bitmap with default parameters.
// Reference pixels: frame f (r,c>0) = {0,f,(r+c)%16}; explosion = {C,(r^c)%16}.
module tb_animated_sprite_bitmap;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        startOfFrame;
    logic        hit;
    logic        revive;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        exploding;
    logic        dead;

    int checks   = 0;
    int failures = 0;

    animated_sprite_bitmap dut (
        .clk             (clk),
        .resetN          (resetN),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .startOfFrame    (startOfFrame),
        .hit             (hit),
        .revive          (revive),
        .drawingRequest  (drawingRequest),
        .RGBout          (RGBout),
        .exploding       (exploding),
        .dead            (dead)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; InsideRectangle = 1'b1; offsetX = 11'd0; offsetY = 11'd0;
        startOfFrame = 1'b0; hit = 1'b0; revive = 1'b0;
        repeat (3) tick();
        checks++; if (RGBout !== 8'hFF) begin failures++; $display("FAIL reset_rgb got=%h exp=ff", RGBout); end
        checks++; if (drawingRequest !== 1'b0) begin failures++; $display("FAIL reset_dr got=%b exp=0", drawingRequest); end
        checks++; if (exploding !== 1'b0) begin failures++; $display("FAIL reset_exploding got=%b exp=0", exploding); end
        checks++; if (dead !== 1'b0) begin failures++; $display("FAIL reset_dead got=%b exp=0", dead); end
        resetN = 1'b1;
        repeat (2) tick();
        checks++; if (RGBout !== 8'hFF) begin failures++; $display("FAIL post_reset_rgb got=%h exp=ff", RGBout); end
        checks++; if (drawingRequest !== 1'b0) begin failures++; $display("FAIL post_reset_dr got=%b exp=0", drawingRequest); end
    endtask

    task automatic test_pixel();
        offsetX = 11'd19; offsetY = 11'd21;
        #1;
        checks++; if (RGBout !== 8'hFF) begin failures++; $display("FAIL latency_before_edge got=%h exp=ff", RGBout); end
        tick();
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL pix_19_21 got=%h exp=03", RGBout); end
        checks++; if (drawingRequest !== 1'b1) begin failures++; $display("FAIL pix_19_21_dr got=%b exp=1", drawingRequest); end
        offsetX = 11'd60; tick();
        checks++; if (RGBout !== 8'hFF) begin failures++; $display("FAIL col_out_of_range got=%h exp=ff", RGBout); end
        checks++; if (drawingRequest !== 1'b0) begin failures++; $display("FAIL col_out_dr got=%b exp=0", drawingRequest); end
        offsetX = 11'd19; offsetY = 11'd51; tick();
        checks++; if (RGBout !== 8'h02) begin failures++; $display("FAIL last_row got=%h exp=02", RGBout); end
        offsetY = 11'd52; tick();
        checks++; if (RGBout !== 8'hFF) begin failures++; $display("FAIL row_out_of_range got=%h exp=ff", RGBout); end
        offsetY = 11'd21; InsideRectangle = 1'b0; tick();
        checks++; if (RGBout !== 8'hFF) begin failures++; $display("FAIL outside_rect got=%h exp=ff", RGBout); end
        InsideRectangle = 1'b1; tick();
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL inside_again got=%h exp=03", RGBout); end
    endtask

    task automatic test_animation();
        pulse_sof(15); tick();
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL anim_15 got=%h exp=03", RGBout); end
        pulse_sof(1); tick();
        checks++; if (RGBout !== 8'h13) begin failures++; $display("FAIL anim_16 got=%h exp=13", RGBout); end
        pulse_sof(16); tick();
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL anim_32 got=%h exp=03", RGBout); end
    endtask

    task automatic test_explode();
        hit = 1'b1; tick(); hit = 1'b0;
        checks++; if (exploding !== 1'b1) begin failures++; $display("FAIL hit_exploding got=%b exp=1", exploding); end
        checks++; if (dead !== 1'b0) begin failures++; $display("FAIL hit_dead got=%b exp=0", dead); end
        tick();
        checks++; if (RGBout !== 8'hC3) begin failures++; $display("FAIL explosion_pix got=%h exp=c3", RGBout); end
        pulse_sof(23);
        checks++; if (exploding !== 1'b1) begin failures++; $display("FAIL explode_23 got=%b exp=1", exploding); end
        pulse_sof(1);
        checks++; if (dead !== 1'b1 || exploding !== 1'b0) begin failures++; $display("FAIL explode_24 dead=%b exploding=%b exp=1,0", dead, exploding); end
        tick();
        checks++; if (RGBout !== 8'hFF || drawingRequest !== 1'b0) begin failures++; $display("FAIL dead_pix got=%h dr=%b exp=ff,0", RGBout, drawingRequest); end
        offsetX = 11'd20; offsetY = 11'd20; tick();
        checks++; if (drawingRequest !== 1'b0) begin failures++; $display("FAIL dead_pix2 dr=%b exp=0", drawingRequest); end
        offsetX = 11'd19; offsetY = 11'd21;
    endtask

    task automatic test_dead_hit();
        hit = 1'b1; tick(); hit = 1'b0;
        checks++; if (dead !== 1'b1 || exploding !== 1'b0) begin failures++; $display("FAIL dead_hit dead=%b exploding=%b exp=1,0", dead, exploding); end
    endtask

    task automatic test_hit_revive();
        revive = 1'b1; tick(); revive = 1'b0;
        checks++; if (dead !== 1'b0 || exploding !== 1'b0) begin failures++; $display("FAIL revive_dead dead=%b exploding=%b exp=0,0", dead, exploding); end
        tick();
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL revive_pix got=%h exp=03", RGBout); end
        pulse_sof(16); tick();
        checks++; if (RGBout !== 8'h13) begin failures++; $display("FAIL pre_hit_frame1 got=%h exp=13", RGBout); end
        hit = 1'b1; tick(); hit = 1'b0;
        checks++; if (exploding !== 1'b1) begin failures++; $display("FAIL hit2_exploding got=%b exp=1", exploding); end
        hit = 1'b1; revive = 1'b1; tick(); hit = 1'b0; revive = 1'b0;
        checks++; if (exploding !== 1'b0 || dead !== 1'b0) begin failures++; $display("FAIL hit_revive exploding=%b dead=%b exp=0,0", exploding, dead); end
        tick();
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL hit_revive_frame0 got=%h exp=03", RGBout); end
    endtask

    task automatic test_reset_mid();
        pulse_sof(16);
        hit = 1'b1; tick(); hit = 1'b0;
        pulse_sof(10);
        checks++; if (exploding !== 1'b1) begin failures++; $display("FAIL mid_exploding got=%b exp=1", exploding); end
        resetN = 1'b0; #2;
        checks++; if (exploding !== 1'b0 || RGBout !== 8'hFF || drawingRequest !== 1'b0) begin failures++; $display("FAIL async_reset exploding=%b rgb=%h dr=%b exp=0,ff,0", exploding, RGBout, drawingRequest); end
        tick(); resetN = 1'b1; tick(); tick();
        checks++; if (dead !== 1'b0 || exploding !== 1'b0) begin failures++; $display("FAIL mid_release dead=%b exploding=%b exp=0,0", dead, exploding); end
        checks++; if (RGBout !== 8'h03) begin failures++; $display("FAIL mid_release_frame0 got=%h exp=03", RGBout); end
    endtask

    task automatic test_hit_sof();
        pulse_sof(15);
        hit = 1'b1; startOfFrame = 1'b1; tick(); hit = 1'b0; startOfFrame = 1'b0;
        checks++; if (exploding !== 1'b1) begin failures++; $display("FAIL hit_sof_exploding got=%b exp=1", exploding); end
        pulse_sof(23);
        checks++; if (exploding !== 1'b1 || dead !== 1'b0) begin failures++; $display("FAIL hit_sof_cnt0 exploding=%b dead=%b exp=1,0", exploding, dead); end
        pulse_sof(1);
        checks++; if (dead !== 1'b1) begin failures++; $display("FAIL hit_sof_dead got=%b exp=1", dead); end
        revive = 1'b1; tick(); revive = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_animation();
        test_explode();
        test_dead_hit();
        test_hit_revive();
        test_reset_mid();
        test_hit_sof();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
